// File: rtl/gates_vector_checker_if.sv
// Bundles the checker's stimulus/response and result signals; master is the checker, slave is the host plus the gates block.
// Pure wiring, no latency; there is no backpressure on this bundle.
interface gates_vector_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       y1;
    logic       y2;
    logic       y3;
    logic       y4;
    logic       y5;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] vec_fail;
    logic [4:0] gate_fail;

    modport master (
        input  start, y1, y2, y3, y4, y5,
        output a, b, busy, done, pass, err_count, vec_fail, gate_fail
    );

    modport slave (
        output start, y1, y2, y3, y4, y5,
        input  a, b, busy, done, pass, err_count, vec_fail, gate_fail
    );
endinterface

// File: rtl/gates_vector_checker.sv
// Sweeps a/b through 00,01,10,11, holds each SETTLE+1 cycles, checks y1..y5 against the gate truth table.
// Results after 4*(SETTLE+1) cycles; start is ignored while busy, never queued.
module gates_vector_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    gates_vector_checker_if.master chk
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] vec_q, vec_d;
    logic [4:0] gate_q, gate_d;

    logic [4:0] y_obs;
    logic [4:0] y_exp;
    logic [4:0] mis;

    assign y_obs = {chk.y5, chk.y4, chk.y3, chk.y2, chk.y1};
    assign y_exp = {~(a_q | b_q), ~(a_q & b_q), a_q ^ b_q, a_q | b_q, a_q & b_q};

    // Case inequality so an X or Z on a gate output counts as a mismatch in simulation.
    always_comb begin
        mis = '0;
        for (int k = 0; k < 5; k++) begin
            mis[k] = (y_obs[k] !== y_exp[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        vec_d   = vec_q;
        gate_d  = gate_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (chk.start) begin
                    state_d = ST_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = CNT_LOAD;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 3'd0;
                    vec_d   = 4'd0;
                    gate_d  = 5'd0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (|mis) begin
                    vec_d  = vec_q | 4'(4'b0001 << idx_q);
                    gate_d = gate_q | mis;
                    err_d  = err_q + 3'd1;
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 3'd0);
                end else begin
                    state_d    = ST_SETTLE;
                    idx_d      = idx_q + 2'd1;
                    cnt_d      = CNT_LOAD;
                    {a_d, b_d} = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            vec_q   <= 4'd0;
            gate_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            gate_q  <= gate_d;
        end
    end

    assign chk.a         = a_q;
    assign chk.b         = b_q;
    assign chk.busy      = busy_q;
    assign chk.done      = done_q;
    assign chk.pass      = pass_q;
    assign chk.err_count = err_q;
    assign chk.vec_fail  = vec_q;
    assign chk.gate_fail = gate_q;

endmodule

// File: tb/tb_gates_vector_checker.sv
// Drives two checkers (SETTLE=2 and SETTLE=1) against a behavioural gates model with selectable faults.
module tb_gates_vector_checker;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // 0 correct, 1 y3 stuck at 0, 2 y1 driven X, 3 per-vector random flip mask
    logic [1:0]  mode;
    logic [19:0] fmask;
    logic        xb;

    gates_vector_checker_if if0 ();
    gates_vector_checker_if if1 ();

    gates_vector_checker #(.SETTLE(2)) dut0 (.clk(clk), .reset(reset), .chk(if0));
    gates_vector_checker #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .chk(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] truth(input logic a_v, input logic b_v);
        int s;
        s = int'(a_v) + int'(b_v);
        return {(s == 0), (s != 2), (s == 1), (s >= 1), (s == 2)};
    endfunction

    function automatic logic [4:0] gates_out(input logic a_v, input logic b_v, input logic [1:0] m,
                                             input logic [19:0] fm, input logic xv);
        logic [4:0] o;
        int         iv;
        o  = truth(a_v, b_v);
        iv = int'({a_v, b_v});
        case (m)
            2'd1:    o[2] = 1'b0;
            2'd2:    o[0] = xv;
            2'd3:    o = o ^ fm[iv*5 +: 5];
            default: o = o;
        endcase
        return o;
    endfunction

    always_comb begin
        {if0.y5, if0.y4, if0.y3, if0.y2, if0.y1} = gates_out(if0.a, if0.b, mode, fmask, xb);
    end

    always_comb begin
        {if1.y5, if1.y4, if1.y3, if1.y2, if1.y1} = gates_out(if1.a, if1.b, 2'd0, 20'd0, 1'b0);
    end

    function automatic void model(input logic [1:0] m, input logic [19:0] fm, input logic xv,
                                  output logic [2:0] ec, output logic [3:0] vf, output logic [4:0] gf);
        logic [4:0] e;
        logic [4:0] o;
        ec = 3'd0;
        vf = 4'd0;
        gf = 5'd0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] iv;
            logic       bad;
            iv  = 2'(i);
            e   = truth(iv[1], iv[0]);
            o   = gates_out(iv[1], iv[0], m, fm, xv);
            bad = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (o[k] !== e[k]) begin
                    gf[k] = 1'b1;
                    bad   = 1'b1;
                end
            end
            if (bad) begin
                vf[i] = 1'b1;
                ec    = ec + 3'd1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag, input bit hold);
        logic [2:0] ec;
        logic [3:0] vf;
        logic [4:0] gf;
        int busy_n, ab_bad, done_at;
        bit seen;
        model(mode, fmask, xb, ec, vf, gf);
        @(negedge clk);
        if0.start = 1'b1;
        busy_n  = 0;
        ab_bad  = 0;
        done_at = -1;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (!hold) begin
                if (k == 0 || k == 6) if0.start = 1'b0;
                if (k == 5) if0.start = 1'b1;
            end
            if (if0.busy) busy_n++;
            if (if0.busy && if0.done) ab_bad++;
            if ({if0.a, if0.b} !== ((k < 12) ? 2'(k / 3) : 2'b00)) ab_bad++;
            if (if0.done && done_at < 0) done_at = k;
        end
        chk({tag, "_busy_cycles"}, busy_n, 12);
        chk({tag, "_done_cycle"}, done_at, 12);
        chk({tag, "_ab_seq"}, ab_bad, 0);
        chk({tag, "_pass"}, 32'(if0.pass), 32'(ec == 3'd0));
        chk({tag, "_err_count"}, 32'(if0.err_count), 32'(ec));
        chk({tag, "_vec_fail"}, 32'(if0.vec_fail), 32'(vf));
        chk({tag, "_gate_fail"}, 32'(if0.gate_fail), 32'(gf));
        if (hold) begin
            @(posedge clk);
            #1;
            chk({tag, "_restart_busy"}, 32'(if0.busy), 32'd1);
            chk({tag, "_restart_cleared"},
                32'({if0.done, if0.pass, if0.err_count, if0.vec_fail, if0.gate_fail}), 32'd0);
            if0.start = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(posedge clk);
                #1;
                seen = if0.done;
            end
            chk({tag, "_restart_done"}, 32'(seen), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        mode      = 2'd0;
        fmask     = 20'd0;
        xb        = 1'bx;
        if0.start = 1'b0;
        if1.start = 1'b0;
        reset     = 1'b1;
        #1;
        chk("reset_outputs0",
            32'({if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count, if0.vec_fail, if0.gate_fail}), 32'd0);
        chk("reset_outputs1",
            32'({if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.err_count, if1.vec_fail, if1.gate_fail}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_activity", 32'({if0.busy, if0.done}), 32'd0);

        mode = 2'd0;
        sweep("correct", 1'b0);
        mode = 2'd1;
        sweep("y3_stuck0", 1'b0);
        mode = 2'd2;
        sweep("y1_x", 1'b0);
        mode = 2'd1;
        sweep("hold_start", 1'b1);

        // Abort mid-sweep with the y3 fault attached.
        mode = 2'd1;
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_outputs",
            32'({if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count, if0.vec_fail, if0.gate_fail}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 32'({if0.busy, if0.done, if0.a, if0.b}), 32'd0);
        mode = 2'd0;
        sweep("after_reset", 1'b0);

        for (int r = 0; r < 6; r++) begin
            mode = 2'd3;
            for (int v = 0; v < 4; v++) begin
                fmask[v*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : 5'd0;
            end
            sweep($sformatf("random%0d", r), 1'b0);
        end

        begin
            int busy_n, ab_bad, done_at;
            busy_n  = 0;
            ab_bad  = 0;
            done_at = -1;
            @(negedge clk);
            if1.start = 1'b1;
            for (int k = 0; k <= 8; k++) begin
                @(posedge clk);
                #1;
                if (k == 0) if1.start = 1'b0;
                if (if1.busy) busy_n++;
                if ({if1.a, if1.b} !== ((k < 8) ? 2'(k / 2) : 2'b00)) ab_bad++;
                if (if1.done && done_at < 0) done_at = k;
            end
            chk("settle1_busy_cycles", busy_n, 8);
            chk("settle1_done_cycle", done_at, 8);
            chk("settle1_ab_seq", ab_bad, 0);
            chk("settle1_results",
                32'({if1.pass, if1.err_count, if1.vec_fail, if1.gate_fail}), 32'h1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gates_vector_checker.md
# gates_vector_checker

Hardware self-checking stimulus stage that sits directly upstream of the two-input `gates` block (AND/OR/XOR/NAND/NOR outputs y1..y5). On `start`, it steps `a`/`b` through all four input combinations and waits a programmable settle time after each. It then samples y1..y5 and compares them against the expected truth table. It reports per-vector and per-gate failure masks, a failing-vector count and a pass flag, so the gates block can be checked on-board without a simulator.

## Interface

Parameters:
- `SETTLE`, default 2: cycles `a`/`b` are held before y1..y5 are sampled. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset. Clears all state immediately.
- `start`  in  1  level-sampled request to run one full sweep.
- `a`  out  1  stimulus to the gates block.
- `b`  out  1  stimulus to the gates block.
- `y1`..`y5`  in  1 each  gates outputs: AND, OR, XOR, NAND, NOR.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; results valid.
- `pass`  out  1  `done` and no vector failed.
- `err_count`  out  3  number of failing vectors, 0..4.
- `vec_fail`  out  4  bit i set if vector i failed.
- `gate_fail`  out  5  bit k-1 set if output yk mismatched in any vector.

## Operation

- Vector index `idx` runs 0..3, with `a = idx[1]` and `b = idx[0]`. The resulting order is (0,0), (0,1), (1,0), (1,1).
- Expected outputs: y1=a&b, y2=a|b, y3=a^b, y4=~(a&b), y5=~(a|b).
- Comparison uses exact four-state equality. An X or Z on any yk is a mismatch.
- A vector fails if any of y1..y5 mismatches.
- State machine:
  - IDLE: `a`=`b`=0, `busy`=0. If `start`=1, go to SETTLE and clear `idx`, `err_count`, `vec_fail`, `gate_fail`, `done`, `pass`. Load the settle counter with SETTLE-1.
  - SETTLE: `busy`=1 and `a`/`b` are driven from `idx`. The counter decrements each cycle. The transition to CHECK happens on the edge where the counter is 0, so SETTLE lasts exactly SETTLE cycles.
  - CHECK: `busy`=1. One cycle; y1..y5 are sampled at the closing edge.
    - On mismatch, set `vec_fail[idx]`, OR the mismatching bits into `gate_fail`, and increment `err_count`.
    - If `idx`=3, go to DONE. Otherwise increment `idx`, reload the counter, and return to SETTLE.
  - DONE: `busy`=0, `done`=1, `pass`=(`err_count`==0). Results are held and `a`=`b`=0.
    - `start`=1 behaves exactly as in IDLE: all results are cleared and a new sweep starts.
- `start` is ignored while `busy`=1. There is no queuing.
- `err_count` cannot exceed 4, so no saturation logic is needed.

## Timing

- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `vec_fail`=0, `gate_fail`=0. State is IDLE.
- Reset asserted mid-sweep aborts immediately, without waiting for a clock edge, to those values. After reset is released, nothing happens until a new `start`.
- Start accepted at edge E0:
  - `busy`=1 and `a`/`b`=(0,0) are visible after E0.
  - Vector i is driven from edge E0+i·(SETTLE+1).
  - Vector i is sampled at edge E0+(i+1)·(SETTLE+1).
- `done` rises after edge E0+4·(SETTLE+1). With the default, that is 12 cycles.
- `busy` falls in the same cycle that `done` rises. `busy` and `done` are never both 1.
- `a`/`b` change only on the edge leaving CHECK, so they are stable for all SETTLE+1 cycles of their vector.
- All outputs are registered. There is no combinational path from y1..y5 to any output.

## Test plan

- Correct gates model attached, SETTLE=2, pulse `start`:
  - `busy` is high for exactly 12 cycles.
  - Then `done`=1, `pass`=1, `err_count`=0, `vec_fail`=4'b0000, `gate_fail`=5'b00000.
  - `a`/`b` sequence observed as 00, 01, 10, 11.
- y3 stuck at 0, otherwise correct: `err_count`=2, `vec_fail`=4'b0110, `gate_fail`=5'b00100, `pass`=0.
- y1 driven X throughout: `err_count`=4, `vec_fail`=4'b1111, `gate_fail`=5'b00001, `pass`=0.
- `start` held high for the whole sweep, then a second `start` pulse mid-sweep:
  - Exactly one sweep runs and `done` rises at cycle 12.
  - `start` still high in DONE begins a new sweep, which clears the results on that edge.
- Reset asserted at cycle 5 of a sweep (with the y3 fault present):
  - All outputs are 0 immediately.
  - A following `start` with the correct model gives `pass`=1, with no stale `vec_fail` or `gate_fail` bits.
- SETTLE=1, correct model: `done` after 8 cycles, and each vector is held for 2 cycles.
